// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and constants for the Ascon AEAD controller.
package ascon_pack;

    localparam int unsigned ROUND_W        = 4;
    localparam int unsigned BLK_W          = 4;
    localparam int unsigned ROUNDS_TOTAL   = 12;
    localparam int unsigned ROUNDS_A_START = 0;
    localparam int unsigned ROUNDS_B_START = 6;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS_TOTAL - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_AD_WAIT,
        ST_AD,
        ST_PT_WAIT,
        ST_PT,
        ST_FINAL,
        ST_DONE
    } type_state;

endpackage

// File: rtl/ascon_ctrl_fsm_if.sv
// Request/data handshake between the message source and the Ascon controller.
interface ascon_ctrl_fsm_if;
    logic start_i;
    logic data_valid_i;
    logic data_ready_o;

    modport master (output start_i, output data_valid_i, input data_ready_o);
    modport slave  (input start_i, input data_valid_i, output data_ready_o);
endinterface

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Permutation round index: increments per round, reloads to the p^a or p^b start.
module ascon_round_counter #(
    parameter int unsigned W      = 4,
    parameter int unsigned LOAD_A = 0,
    parameter int unsigned LOAD_B = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         load_i,
    input  logic         load_b_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_b_i ? W'(LOAD_B) : W'(LOAD_A);
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Ascon encryption controller: sequences init, AD, plaintext and finalization
// permutations and drives the datapath selects for each round.
module ascon_ctrl_fsm #(
    parameter int unsigned NB_BLOCKS      = 4,
    parameter int unsigned ROUNDS_A_START = ascon_pack::ROUNDS_A_START,
    parameter int unsigned ROUNDS_B_START = ascon_pack::ROUNDS_B_START
) (
    input  logic                clock_i,
    input  logic                resetb_i,
    ascon_ctrl_fsm_if.slave     ctrl,
    output logic [3:0]          round_o,
    output logic                init_state_o,
    output logic                en_reg_state_o,
    output logic                xor_data_begin_o,
    output logic                xor_key_begin_o,
    output logic                xor_key_end_o,
    output logic                xor_lsb_end_o,
    output logic                en_cipher_o,
    output logic                en_tag_o,
    output logic                cipher_valid_o,
    output logic                busy_o,
    output logic                end_o
);

    import ascon_pack::*;

    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NB_BLOCKS - 1);

    type_state          state_q, state_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [ROUND_W-1:0] cnt;
    logic               cnt_en, cnt_ld, cnt_ld_b;
    logic               cipher_valid_q;
    logic               last_round;

    ascon_round_counter #(
        .W      (ROUND_W),
        .LOAD_A (ROUNDS_A_START),
        .LOAD_B (ROUNDS_B_START)
    ) u_round_counter (
        .clk_i    (clock_i),
        .rst_ni   (resetb_i),
        .en_i     (cnt_en),
        .load_i   (cnt_ld),
        .load_b_i (cnt_ld_b),
        .cnt_o    (cnt)
    );

    assign last_round = (cnt == LAST_ROUND);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q        <= ST_IDLE;
            blk_q          <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            blk_q          <= blk_d;
            cipher_valid_q <= en_cipher_o;
        end
    end

    // Counter is preloaded on each phase exit so that the wait state already
    // presents the correct first round (p^b start, or p^a start before FINAL).
    always_comb begin
        state_d          = state_q;
        blk_d            = blk_q;
        cnt_en           = 1'b0;
        cnt_ld           = 1'b0;
        cnt_ld_b         = 1'b0;
        init_state_o     = 1'b0;
        en_reg_state_o   = 1'b0;
        xor_data_begin_o = 1'b0;
        xor_key_begin_o  = 1'b0;
        xor_key_end_o    = 1'b0;
        xor_lsb_end_o    = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        end_o            = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl.start_i) begin
                    init_state_o   = 1'b1;
                    en_reg_state_o = 1'b1;
                    cnt_en         = 1'b1;
                    state_d        = ST_INIT;
                end
            end
            ST_INIT: begin
                en_reg_state_o = 1'b1;
                if (last_round) begin
                    xor_key_end_o = 1'b1;
                    cnt_ld        = 1'b1;
                    cnt_ld_b      = 1'b1;
                    state_d       = ST_AD_WAIT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_AD_WAIT: begin
                if (ctrl.data_valid_i) begin
                    xor_data_begin_o = 1'b1;
                    en_reg_state_o   = 1'b1;
                    cnt_en           = 1'b1;
                    state_d          = ST_AD;
                end
            end
            ST_AD: begin
                en_reg_state_o = 1'b1;
                if (last_round) begin
                    xor_lsb_end_o = 1'b1;
                    cnt_ld        = 1'b1;
                    cnt_ld_b      = (LAST_BLK != '0);
                    blk_d         = '0;
                    state_d       = ST_PT_WAIT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_PT_WAIT: begin
                if (ctrl.data_valid_i) begin
                    xor_data_begin_o = 1'b1;
                    en_cipher_o      = 1'b1;
                    en_reg_state_o   = 1'b1;
                    cnt_en           = 1'b1;
                    if (blk_q == LAST_BLK) begin
                        xor_key_begin_o = 1'b1;
                        state_d         = ST_FINAL;
                    end else begin
                        state_d = ST_PT;
                    end
                end
            end
            ST_PT: begin
                en_reg_state_o = 1'b1;
                if (last_round) begin
                    blk_d    = BLK_W'(blk_q + BLK_W'(1));
                    cnt_ld   = 1'b1;
                    cnt_ld_b = (BLK_W'(blk_q + BLK_W'(1)) != LAST_BLK);
                    state_d  = ST_PT_WAIT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_FINAL: begin
                en_reg_state_o = 1'b1;
                if (last_round) begin
                    xor_key_end_o = 1'b1;
                    en_tag_o      = 1'b1;
                    cnt_ld        = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                end_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign round_o           = cnt;
    assign cipher_valid_o    = cipher_valid_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign ctrl.data_ready_o = (state_q == ST_AD_WAIT) || (state_q == ST_PT_WAIT);

endmodule
